// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read bus between fetch_ctrl (master) and the instruction memory (slave).
// One-cycle read strobe with address; the memory answers later with a one-cycle done strobe and data.
interface fetch_ctrl_if #(
    parameter int N = 16
);
    logic         mem_rd;
    logic [N-1:0] mem_addr;
    logic         mem_done;
    logic [N-1:0] mem_data;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_done,
        input  mem_data
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_done,
        output mem_data
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads a variable-latency instruction memory and presents instructions to decode.
// Optional fetch timeout (sticky err + halt) is enabled by defining FETCH_TIMEOUT_EN.
module fetch_ctrl #(
    parameter int           N              = 16,
    parameter logic [N-1:0] RESET_PC       = '0,
    parameter int           TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_ctrl_if.master  mem,
    input  logic          redirect_i,
    input  logic [N-1:0]  redirect_pc_i,
    input  logic          stall_i,
    input  logic          halt_i,
    output logic [N-1:0]  instr_o,
    output logic [N-1:0]  instr_pc_o,
    output logic [N-1:0]  pc_inc_o,
    output logic          instr_valid_o,
    output logic          halted_o,
    output logic          err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_VALID,
        S_HALT
    } state_e;

    localparam logic [N-1:0] PcEvenMask = ~N'(1);
    localparam logic [N-1:0] ResetPc    = RESET_PC & PcEvenMask;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic         squash_q, squash_d;
    logic [N-1:0] instr_q, instr_d;
    logic [N-1:0] instr_pc_q, instr_pc_d;
    logic [N-1:0] pc_inc_q, pc_inc_d;
    logic         mem_rd;
    logic         timeout_hit;

    logic [N-1:0] redirect_tgt;
    logic [N-1:0] pc_next;

    assign redirect_tgt = redirect_pc_i & PcEvenMask;
    assign pc_next      = pc_q + N'(2);

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    // The counter only lives while the FSM stays in WAIT, so any exit clears it.
    assign timeout_hit = (state_q == S_WAIT) && !mem.mem_done &&
                         (tmo_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = '0;
        err_d = err_q | timeout_hit;
        if (state_q == S_WAIT && state_d == S_WAIT) begin
            tmo_d = tmo_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= ResetPc;
            squash_q   <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            pc_inc_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            squash_q   <= squash_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            pc_inc_q   <= pc_inc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        squash_d   = squash_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pc_inc_d   = pc_inc_q;
        mem_rd     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_rd  = 1'b1;
                state_d = S_WAIT;
                if (redirect_i) begin
                    pc_d     = redirect_tgt;
                    squash_d = 1'b1;
                end
            end

            // A request overtaken by a redirect is still allowed to complete, but its data is dropped.
            S_WAIT: begin
                if (mem.mem_done) begin
                    if (squash_q || redirect_i) begin
                        squash_d = 1'b0;
                        state_d  = S_FETCH;
                        if (redirect_i) begin
                            pc_d = redirect_tgt;
                        end
                    end else begin
                        instr_d    = mem.mem_data;
                        instr_pc_d = pc_q;
                        pc_inc_d   = pc_next;
                        pc_d       = pc_next;
                        state_d    = S_VALID;
                    end
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                end else if (redirect_i) begin
                    pc_d     = redirect_tgt;
                    squash_d = 1'b1;
                end
            end

            S_VALID: begin
                if (redirect_i) begin
                    pc_d    = redirect_tgt;
                    state_d = S_FETCH;
                end else if (halt_i) begin
                    state_d = S_HALT;
                end else if (!stall_i) begin
                    state_d = S_FETCH;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem.mem_rd    = mem_rd;
    assign mem.mem_addr  = pc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign pc_inc_o      = pc_inc_q;
    assign instr_valid_o = (state_q == S_VALID);
    assign halted_o      = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a memory responder checks read addresses against a queue and a
// monitor checks each presented instruction against a scoreboard filled as stimulus is driven.
module tb_fetch_ctrl;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pcInc;
    } expT;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [15:0] redirectPc;
    logic        stall;
    logic        halt;
    logic [15:0] instr;
    logic [15:0] instrPc;
    logic [15:0] pcInc;
    logic        instrValid;
    logic        halted;
    logic        err;

    logic        rstB;
    logic [15:0] instrB;
    logic [15:0] instrPcB;
    logic [15:0] pcIncB;
    logic        instrValidB;
    logic        haltedB;
    logic        errB;

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;
    int cycRel     = 0;

    logic [15:0] addrQ[$];
    expT         instrQ[$];
    int          rdCyc[$];

    logic        memAuto      = 1'b1;
    int          memLat       = 1;
    logic        overrideEn   = 1'b0;
    logic [15:0] overrideData = 16'h0000;
    logic [15:0] reqAddr;
    logic        prevValid;

    fetch_ctrl_if #(.N(16)) memIf ();
    fetch_ctrl_if #(.N(16)) memIfB ();

    fetch_ctrl #(
        .N             (16),
        .RESET_PC      (16'h0000),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem          (memIf),
        .redirect_i   (redirect),
        .redirect_pc_i(redirectPc),
        .stall_i      (stall),
        .halt_i       (halt),
        .instr_o      (instr),
        .instr_pc_o   (instrPc),
        .pc_inc_o     (pcInc),
        .instr_valid_o(instrValid),
        .halted_o     (halted),
        .err_o        (err)
    );

    fetch_ctrl #(
        .N             (16),
        .RESET_PC      (16'hFFFE),
        .TIMEOUT_CYCLES(8)
    ) dutB (
        .clk          (clk),
        .rst_n        (rstB),
        .mem          (memIfB),
        .redirect_i   (1'b0),
        .redirect_pc_i(16'h0000),
        .stall_i      (1'b0),
        .halt_i       (1'b0),
        .instr_o      (instrB),
        .instr_pc_o   (instrPcB),
        .pc_inc_o     (pcIncB),
        .instr_valid_o(instrValidB),
        .halted_o     (haltedB),
        .err_o        (errB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return a ^ 16'hA5A7;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [15:0] rpc, input logic s, input logic h);
        redirect   = r;
        redirectPc = rpc;
        stall      = s;
        halt       = h;
    endtask

    task automatic pushInstr(input logic [15:0] pc);
        expT e;
        e.instr = memWord(pc);
        e.pc    = pc;
        e.pcInc = pc + 16'd2;
        instrQ.push_back(e);
    endtask

    task automatic waitNextValid(input string tag);
        int n;
        n = 0;
        while (instrValid !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        while (instrValid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'b0, instrValid}, 32'd1);
    endtask

    // Instruction memory model for the main DUT: checks every read address, answers after memLat cycles.
    initial begin
        memIf.mem_done = 1'b0;
        memIf.mem_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (memIf.mem_rd === 1'b1) begin
                reqAddr = memIf.mem_addr;
                rdCyc.push_back(cyc);
                if (addrQ.size() == 0) begin
                    checkOutput("rd_without_expect", 32'(addrQ.size()), 32'd1);
                end else begin
                    checkOutput("mem_addr", {16'b0, reqAddr}, {16'b0, addrQ.pop_front()});
                end
                if (memAuto) begin
                    repeat (memLat) @(posedge clk);
                    #1;
                    memIf.mem_done = 1'b1;
                    memIf.mem_data = overrideEn ? overrideData : memWord(reqAddr);
                    @(posedge clk);
                    #1;
                    memIf.mem_done = 1'b0;
                end
            end
        end
    end

    initial begin
        memIfB.mem_done = 1'b0;
        memIfB.mem_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (memIfB.mem_rd === 1'b1) begin
                @(posedge clk);
                #1;
                memIfB.mem_done = 1'b1;
                memIfB.mem_data = memIfB.mem_addr ^ 16'h1234;
                @(posedge clk);
                #1;
                memIfB.mem_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor: each new presentation to decode pops one expected instruction.
    initial begin
        expT e;
        prevValid = 1'b0;
        forever begin
            @(negedge clk);
            if (instrValid === 1'b1 && !prevValid) begin
                if (instrQ.size() == 0) begin
                    checkOutput("valid_without_expect", 32'(instrQ.size()), 32'd1);
                end else begin
                    e = instrQ.pop_front();
                    checkOutput("sb_instr",    {16'b0, instr},   {16'b0, e.instr});
                    checkOutput("sb_instr_pc", {16'b0, instrPc}, {16'b0, e.pc});
                    checkOutput("sb_pc_inc",   {16'b0, pcInc},   {16'b0, e.pcInc});
                end
            end
            prevValid = (instrValid === 1'b1);
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        rstB  = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

        #3;
        checkOutput("rst_mem_rd",      {31'b0, memIf.mem_rd}, 32'd0);
        checkOutput("rst_instr_valid", {31'b0, instrValid},   32'd0);
        checkOutput("rst_halted",      {31'b0, halted},       32'd0);
        checkOutput("rst_err",         {31'b0, err},          32'd0);
        checkOutput("rst_instr",       {16'b0, instr},        32'd0);
        checkOutput("rst_mem_addr",    {16'b0, memIf.mem_addr}, 32'd0);

        // Sequential fetch with single-cycle memory, then a 4-cycle stall on the second instruction.
        addrQ.push_back(16'h0000);
        addrQ.push_back(16'h0002);
        addrQ.push_back(16'h0004);
        pushInstr(16'h0000);
        pushInstr(16'h0002);
        pushInstr(16'h0004);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycRel = cyc;

        waitNextValid("valid_pc0");
        waitNextValid("valid_pc2");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stall_valid",    {31'b0, instrValid},   32'd1);
            checkOutput("stall_instr",    {16'b0, instr},        32'h0000A5A5);
            checkOutput("stall_instr_pc", {16'b0, instrPc},      32'h00000002);
            checkOutput("stall_mem_rd",   {31'b0, memIf.mem_rd}, 32'd0);
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        waitNextValid("valid_pc4");
        checkOutput("first_rd_cycle", 32'(rdCyc[0] - cycRel), 32'd1);
        checkOutput("rd_spacing",     32'(rdCyc[1] - rdCyc[0]), 32'd3);

        // Redirect during WAIT: the in-flight 0xDEAD must be dropped and fetch resumes at 0x0040.
        memLat       = 3;
        overrideEn   = 1'b1;
        overrideData = 16'hDEAD;
        addrQ.push_back(16'h0006);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 16'h0041, 1'b0, 1'b0);
        addrQ.push_back(16'h0040);
        pushInstr(16'h0040);
        checkOutput("squash_valid_w1", {31'b0, instrValid}, 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("squash_valid_w2", {31'b0, instrValid}, 32'd0);
        @(negedge clk);
        checkOutput("squash_valid_w3", {31'b0, instrValid}, 32'd0);
        memLat     = 1;
        overrideEn = 1'b0;
        @(negedge clk);
        checkOutput("squash_valid_f",  {31'b0, instrValid},     32'd0);
        checkOutput("squash_refetch",  {16'b0, memIf.mem_addr}, 32'h00000040);

        // Redirect beats halt in VALID; a later lone halt parks the block for good.
        waitNextValid("valid_pc40");
        addrQ.push_back(16'h0100);
        pushInstr(16'h0100);
        applyStimulus(1'b1, 16'h0100, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("redir_wins_halted", {31'b0, halted},       32'd0);
        checkOutput("redir_wins_rd",     {31'b0, memIf.mem_rd}, 32'd1);
        waitNextValid("valid_pc100");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("halt_halted", {31'b0, halted},     32'd1);
        checkOutput("halt_valid",  {31'b0, instrValid}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            @(negedge clk);
            checkOutput("halt_hold_rd",     {31'b0, memIf.mem_rd}, 32'd0);
            checkOutput("halt_hold_halted", {31'b0, halted},       32'd1);
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

        // Leave HALT by reset, then reset again mid-WAIT with a memory response still in flight.
        addrQ.push_back(16'h0000);
        memLat = 2;
        rst_n  = 1'b0;
        #1;
        checkOutput("rst2_halted", {31'b0, halted}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midwait_instr",    {16'b0, instr},        32'd0);
        checkOutput("midwait_instr_pc", {16'b0, instrPc},      32'd0);
        checkOutput("midwait_pc_inc",   {16'b0, pcInc},        32'd0);
        checkOutput("midwait_mem_rd",   {31'b0, memIf.mem_rd}, 32'd0);
        checkOutput("midwait_valid",    {31'b0, instrValid},   32'd0);
        checkOutput("midwait_mem_addr", {16'b0, memIf.mem_addr}, 32'd0);
        memLat = 1;
        addrQ.push_back(16'h0000);
        pushInstr(16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("late_done_seen",  {31'b0, memIf.mem_done}, 32'd1);
        checkOutput("late_done_valid", {31'b0, instrValid},     32'd0);
        checkOutput("late_done_rd",    {31'b0, memIf.mem_rd},   32'd0);
        waitNextValid("valid_after_rst");

        // Withheld memory response: the timeout build halts with err after 8 WAIT cycles.
        memAuto = 1'b0;
        addrQ.push_back(16'h0002);
        @(negedge clk);
        checkOutput("tmo_fetch_rd", {31'b0, memIf.mem_rd}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("tmo_wait_err",    {31'b0, err},    32'd0);
            checkOutput("tmo_wait_halted", {31'b0, halted}, 32'd0);
        end
        @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
        checkOutput("tmo_err",    {31'b0, err},    32'd1);
        checkOutput("tmo_halted", {31'b0, halted}, 32'd1);
`else
        checkOutput("notmo_err",    {31'b0, err},    32'd0);
        checkOutput("notmo_halted", {31'b0, halted}, 32'd0);
`endif

        // Second instance starts at 0xFFFE and must wrap to 0x0000.
        @(posedge clk);
        #1 rstB = 1'b1;
        n = 0;
        while (memIfB.mem_rd !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wrap_first_addr", {16'b0, memIfB.mem_addr}, 32'h0000FFFE);
        n = 0;
        while (instrValidB !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wrap_instr",    {16'b0, instrB},   {16'b0, 16'hFFFE ^ 16'h1234});
        checkOutput("wrap_instr_pc", {16'b0, instrPcB}, 32'h0000FFFE);
        checkOutput("wrap_pc_inc",   {16'b0, pcIncB},   32'h00000000);
        n = 0;
        while (memIfB.mem_rd !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wrap_second_addr", {16'b0, memIfB.mem_addr}, 32'h00000000);

        checkOutput("addr_queue_drained",  32'(addrQ.size()),  32'd0);
        checkOutput("instr_queue_drained", 32'(instrQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
